// File: rtl/tick_period_meter.sv
// Tick period meter: measures clock cycles between rising edges of tick_in and flags lock/overflow.
// Optional input synchronizer enabled by defining TICK_SYNC_EN.
module tick_period_meter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             tick_in,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FIRST = 2'd1,
        S_MEASURE    = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_COUNT - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    if (LOCK_COUNT < 2 || LOCK_COUNT > 15 || SYNC_STAGES < 2) begin : g_bad_params
        $error("tick_period_meter: LOCK_COUNT must be 2..15 and SYNC_STAGES >= 2");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_overflow;
    logic [3:0]       r_match;
    logic             r_tick_q;
    logic             w_tick_s;
    logic             w_rise;

`ifdef TICK_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
        end
    end

    assign w_tick_s = r_sync[SYNC_STAGES-1];
`else
    assign w_tick_s = tick_in;
`endif

    assign w_rise = w_tick_s & ~r_tick_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_overflow     <= 1'b0;
            r_match        <= '0;
            r_tick_q       <= 1'b0;
        end else begin
            r_tick_q       <= w_tick_s;
            r_period_valid <= 1'b0;
            // Clear first so a same-cycle overflow below takes priority.
            if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
            if (!enable) begin
                r_state  <= S_IDLE;
                r_count  <= '0;
                r_locked <= 1'b0;
                r_match  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_count <= '0;
                        r_state <= S_WAIT_FIRST;
                    end
                    S_WAIT_FIRST: begin
                        if (w_rise) begin
                            r_count <= ONE;
                            r_state <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        if (w_rise) begin
                            r_period       <= r_count;
                            r_period_valid <= 1'b1;
                            r_count        <= ONE;
                            if (r_count == r_period) begin
                                if (r_match != LOCK_MAX) begin
                                    r_match <= r_match + 4'd1;
                                    if (r_match + 4'd1 == LOCK_MAX) begin
                                        r_locked <= 1'b1;
                                    end
                                end
                            end else begin
                                r_match  <= '0;
                                r_locked <= 1'b0;
                            end
                        end else if (r_count == '1) begin
                            r_overflow <= 1'b1;
                            r_locked   <= 1'b0;
                            r_match    <= '0;
                            r_count    <= '0;
                            r_state    <= S_WAIT_FIRST;
                        end else begin
                            r_count <= r_count + ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed self-checking bench for tick_period_meter (WIDTH=4 so overflow is reachable quickly).
module tb_tick_period_meter;

    localparam int unsigned W = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         tick_in;
    logic         clear_ovf;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    tick_period_meter #(
        .WIDTH(W),
        .LOCK_COUNT(4),
        .SYNC_STAGES(2)
    ) u_dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .tick_in(tick_in),
        .clear_ovf(clear_ovf),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Drive tick_in for one cycle; outputs are observed 1 time unit after the edge.
    task automatic step(input logic t);
        tick_in = t;
        @(posedge clock);
        #1;
    endtask

    // n-1 low cycles followed by one high cycle, then check the reported period.
    task automatic wait_pulse(input int n, input logic [W-1:0] exp_p, input logic exp_lock);
        for (int i = 0; i < n - 1; i++) begin
            step(1'b0);
            check("gap_valid", 32'(period_valid), 32'd0);
        end
        step(1'b1);
        check("valid", 32'(period_valid), 32'd1);
        check("period", 32'(period), 32'(exp_p));
        check("locked", 32'(locked), 32'(exp_lock));
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        tick_in   = 1'b0;
        clear_ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_period", 32'(period), 32'd0);
        check("rst_valid", 32'(period_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Steady lock at period 5.
        reset_n = 1'b1;
        enable  = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("ref_no_valid", 32'(period_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_pulse(5, 4'd5, (i >= 3));
        end
        check("steady_ovf", 32'(overflow), 32'd0);

        // Rate change to 3: first period of 3 drops lock, fourth regains it.
        wait_pulse(3, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(3, 4'd3, (i == 2));
        end

        // Relock at 5, then drop enable for one cycle.
        for (int i = 0; i < 4; i++) begin
            wait_pulse(5, 4'd5, (i == 3));
        end
        enable = 1'b0;
        step(1'b0);
        check("en_drop_locked", 32'(locked), 32'd0);
        check("en_drop_period", 32'(period), 32'd5);
        enable = 1'b1;
        step(1'b0);
        step(1'b1);
        check("resume_ref_valid", 32'(period_valid), 32'd0);
        wait_pulse(5, 4'd5, 1'b0);

        // Asynchronous reset mid-count.
        step(1'b0);
        step(1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_period", 32'(period), 32'd0);
        check("async_valid", 32'(period_valid), 32'd0);
        check("async_locked", 32'(locked), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("post_rst_ref_valid", 32'(period_valid), 32'd0);

        // Minimum period: toggle every cycle.
        for (int i = 0; i < 4; i++) begin
            wait_pulse(2, 4'd2, (i == 3));
        end

        // Overflow with input held low after a rise.
        for (int i = 0; i < 14; i++) begin
            step(1'b0);
            check("pre_ovf", 32'(overflow), 32'd0);
        end
        step(1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_period_held", 32'(period), 32'd2);
        check("ovf_locked", 32'(locked), 32'd0);
        check("ovf_valid", 32'(period_valid), 32'd0);
        clear_ovf = 1'b1;
        step(1'b0);
        clear_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        step(1'b1);
        check("ovf_ref_valid", 32'(period_valid), 32'd0);
        wait_pulse(7, 4'd7, 1'b0);

        // Boundary: period equal to the counter maximum.
        wait_pulse(15, 4'd15, 1'b0);
        check("boundary_ovf", 32'(overflow), 32'd0);

        // Constant-high input: no further rises, overflow wins over a same-cycle clear.
        for (int i = 0; i < 14; i++) begin
            step(1'b1);
            check("high_valid", 32'(period_valid), 32'd0);
            check("high_pre_ovf", 32'(overflow), 32'd0);
        end
        clear_ovf = 1'b1;
        step(1'b1);
        clear_ovf = 1'b0;
        check("set_wins", 32'(overflow), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            check("high_no_valid", 32'(period_valid), 32'd0);
        end
        check("high_ovf_sticky", 32'(overflow), 32'd1);
        check("high_period_held", 32'(period), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Recovers the divisor from a divided tick train: measures clock cycles between rising edges of `tick_in` and reports the period.
- Detects lock once the period is stable.
- Sits on the PIO clock-enable path as a self-check and monitor for the state-machine clock divider; its output is directly comparable to the programmed divisor.

Parameters:
- WIDTH, 16, width of the period counter and the `period` output.
- LOCK_COUNT, 4, number of consecutive identical periods required to assert `locked`; legal range 2..15.
- SYNC_STAGES, 2, flop depth of the input synchronizer; used only with TICK_SYNC_EN; minimum 2.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- tick_in  input  1  tick train to measure; a rising edge marks a period boundary.
- period  output  WIDTH  last completed period in clock cycles.
- period_valid  output  1  one-cycle pulse when `period` updates.
- locked  output  1  period stable for LOCK_COUNT consecutive measurements.
- overflow  output  1  sticky flag; no edge seen within 2^WIDTH-1 cycles.
- clear_ovf  input  1  synchronous clear of `overflow`.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; `period`=0, `period_valid`=0, `locked`=0, `overflow`=0.
  - Internal counter=0; match count=0; edge-history flop=0; synchronizer flops=0.
- Edge detect:
  - tick_s is the sampled input; tick_q is tick_s delayed one cycle.
  - rise = tick_s & ~tick_q.
  - A constant-high input produces no rises after the first.
- States:
  - IDLE: counter held at 0. Go to WAIT_FIRST when `enable`=1.
  - WAIT_FIRST: wait for rise. On rise, counter<=1 and go to MEASURE.
  - MEASURE:
    - Each cycle without rise: counter<=counter+1.
    - On rise: `period`<=counter, `period_valid`<=1 for one cycle, counter<=1.
  - Any state: `enable`=0 returns to IDLE next cycle and clears `locked` and the match count. `period` holds its value.
- Period arithmetic:
  - Rises at cycles t and t+N yield `period`=N.
  - The minimum measurable period is 2.
  - The first rise after entering WAIT_FIRST never produces `period_valid`.
- Latency: `period_valid` and the new `period` are visible the cycle after the cycle in which rise is high.
- Lock:
  - On each rise in MEASURE, compare counter with the previously reported `period`.
  - Equal: match count increments, saturating at LOCK_COUNT-1.
  - Unequal: match count resets to 0 and `locked` drops on the same update as `period_valid`.
  - `locked` asserts when a match brings the match count to LOCK_COUNT-1, i.e. LOCK_COUNT equal periods in a row.
  - `locked` updates in the same cycle as `period_valid`.
- Overflow:
  - Applies in MEASURE when counter = 2^WIDTH-1 and there is no rise.
  - Effect: `overflow`<=1, `locked`<=0, match count<=0, counter<=0, go to WAIT_FIRST. `period` is unchanged.
- Simultaneous rise and saturation: rise wins; the period 2^WIDTH-1 is reported normally and there is no overflow.
- `clear_ovf`: clears `overflow` next cycle. If a new overflow occurs in the same cycle, set wins.
- Reset mid-measurement: all state is discarded immediately. After release, the first rise is a reference edge only.

Optional Feature:
- Macro: TICK_SYNC_EN.
- Defined: `tick_in` passes through a SYNC_STAGES-deep flop synchronizer before edge detect. All latencies grow by SYNC_STAGES cycles; measured periods are unchanged.
- Undefined: tick_s = `tick_in` directly. `tick_in` must be synchronous to `clock`. `period_valid` latency is exactly 1 cycle after the sampled rise.

Test Plan:
- Steady lock: enable=1, one-cycle `tick_in` pulse every 5 cycles for 6 pulses -> `period`=5 with 5 `period_valid` pulses; `locked`=1 coincident with the 4th `period_valid`; `overflow`=0.
- Rate change: after lock at 5, switch to a pulse every 3 cycles -> next `period`=3 with `locked`=0 on the same cycle; `locked`=1 again after 4 consecutive periods of 3.
- Overflow: WIDTH=4, one rise, then `tick_in` held low -> `overflow`=1 on the 15th count, state WAIT_FIRST, `period` unchanged. `clear_ovf` pulse -> `overflow`=0. Next two rises 7 apart -> `period`=7.
- Boundary period: WIDTH=4, rises 15 cycles apart -> `period`=15, `overflow` stays 0.
- Enable/reset mid-operation: locked at period 5, drop `enable` for 1 cycle -> `locked`=0 and `period` holds 5; resume -> first rise produces no `period_valid`. Assert reset_n low asynchronously mid-count -> all outputs 0 immediately.
- Minimum period: `tick_in` toggling every cycle -> `period`=2, `locked`=1 after 4 periods; constant-high `tick_in` -> no `period_valid`, `overflow` after 2^WIDTH-1 cycles.
